argmax_reader: RTL and testbench
================================

# argmax_reader

Reads the final-layer output feature map written to DRAM by the fully connected layer at OFMAP_BASE, one word per cycle. Finds the largest signed score and its index, and reports the predicted class with a one-cycle done pulse. It sits after the fully connected layer in the inference pipeline and shares the DRAM read port protocol: address and read enable are driven in cycle t, and data is returned on data_in in cycle t+1.

## Interface
- DATA_WIDTH, 32, score word width (signed two's complement, Q16.16)
- ADDR_WIDTH, 18, DRAM word address width
- NUM_CLASSES, 10, number of scores to read (2..16)
- IDX_WIDTH, 4, class index width
- OFMAP_BASE, 18'd131072, DRAM address of score 0
- clk  in  1  system clock
- srstn  in  1  reset; one clock; synchronous, active-low
- enable  in  1  start request; sampled only in IDLE
- data_in  in  DATA_WIDTH  DRAM read data, valid one cycle after the address
- addr_in  out  ADDR_WIDTH  DRAM read address
- dram_en_rd  out  1  DRAM read enable
- class_idx  out  IDX_WIDTH  index of the maximum score, registered
- max_val  out  DATA_WIDTH  maximum score, registered
- done  out  1  one-cycle pulse; results are valid

## Operation
- States (one-hot): IDLE, READ, DRAIN, DONE.
- IDLE: if enable, go to READ. Otherwise stay.
- READ:
  - Read counter cnt_rd runs 0..NUM_CLASSES-1.
  - addr_in = OFMAP_BASE + cnt_rd, dram_en_rd = 1.
  - When cnt_rd == NUM_CLASSES-1: clear cnt_rd and go to DRAIN.
- DRAIN: one cycle with no read issued, so the last word can be captured. Go to DONE.
- DONE: done = 1 for one cycle, then go to IDLE.
- Capture pipeline:
  - rd_vld <= dram_en_rd and rd_idx <= cnt_rd, both registered.
  - When rd_vld is high, data_in belongs to index rd_idx.
- Running max (run_max, run_idx):
  - If rd_idx == 0, load unconditionally. This covers all-negative scores.
  - Otherwise, update only if $signed(data_in) > $signed(run_max).
  - The comparison is strict, so on ties the lowest index wins.
- On entry to DONE, class_idx <= run_idx and max_val <= run_max. Both hold until the next DONE.
- addr_in = 0 and dram_en_rd = 0 in every state except READ.
- enable is ignored in READ, DRAIN and DONE; it is not queued.
- Reset (srstn low at a clock edge), including mid-operation:
  - state = IDLE.
  - cnt_rd, rd_vld, rd_idx, run_max, run_idx, class_idx, max_val and done all cleared to 0.
  - A read in flight is discarded.

## Timing
- Reset values: addr_in 0, dram_en_rd 0, class_idx 0, max_val 0, done 0.
- Let E be the edge at which enable is sampled high in IDLE.
- Reads: cycles E+1 .. E+NUM_CLASSES carry addresses base+0 .. base+NUM_CLASSES-1, one per cycle with no gaps.
- DRAIN is cycle E+NUM_CLASSES+1. The last data word is compared in that cycle.
- done is high in cycle E+NUM_CLASSES+2 (E+12 at the default), and class_idx/max_val are valid in that same cycle.
- Earliest restart: enable sampled in the IDLE cycle right after DONE. Throughput is one run per NUM_CLASSES+3 cycles.
- The block has no stall or backpressure. data_in must be valid exactly one cycle after dram_en_rd.

## Test plan
- Distinct scores:
  - Stimulus: DRAM[131072..131081] = {3,7,1,9,2,0,5,8,4,6} (×65536).
  - Required: addresses 131072..131081 on consecutive cycles; done at E+12; class_idx 3; max_val 9×65536.
- Tie:
  - Stimulus: scores 5 at index 2 and at index 7; all other scores lower.
  - Required: class_idx 2.
- All negative:
  - Stimulus: scores {-1..-10} with -1 at index 0.
  - Required: class_idx 0; max_val 32'hFFFF0000.
- Max at the last index:
  - Stimulus: largest score at index 9.
  - Required: class_idx 9 (checks the DRAIN capture).
- Start handling:
  - Stimulus: enable held high continuously.
  - Required: runs repeat every 13 cycles; a pulse of enable during READ causes no extra run.
  - Required: class_idx/max_val hold their values between done pulses.
- Reset mid-operation:
  - Stimulus: srstn low at E+5, then released and a fresh enable given.
  - Required: all outputs 0 the next cycle; dram_en_rd 0; no done pulse; the fresh enable gives the correct result with no stale max.

Source files
------------

// File: rtl/argmax_reader.sv
// argmax_reader: scans NUM_CLASSES signed scores from DRAM and reports
// the index and value of the largest one with a one-cycle done pulse.
//
// Ports:
//   clk        system clock
//   srstn      synchronous active-low reset
//   enable     start request, sampled only in IDLE
//   data_in    DRAM read data, valid one cycle after the address
//   addr_in    DRAM read address (OFMAP_BASE + index while reading)
//   dram_en_rd DRAM read enable
//   class_idx  registered index of the maximum score
//   max_val    registered maximum score
//   done       one-cycle pulse, class_idx/max_val valid
module argmax_reader #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 18,
    parameter int                    NUM_CLASSES = 10,
    parameter int                    IDX_WIDTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] OFMAP_BASE  = 18'd131072
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic                  dram_en_rd,
    output logic [IDX_WIDTH-1:0]  class_idx,
    output logic [DATA_WIDTH-1:0] max_val,
    output logic                  done
);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        READ  = 4'b0010,
        DRAIN = 4'b0100,
        DONE  = 4'b1000
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

    state_t                state;
    state_t                state_nxt;
    logic [IDX_WIDTH-1:0]  cnt_rd;
    logic [IDX_WIDTH-1:0]  cnt_rd_nxt;

    logic                  rd_vld;
    logic [IDX_WIDTH-1:0]  rd_idx;
    logic [DATA_WIDTH-1:0] run_max;
    logic [IDX_WIDTH-1:0]  run_idx;

    logic                  take;
    logic [DATA_WIDTH-1:0] max_nxt;
    logic [IDX_WIDTH-1:0]  idx_nxt;

    always_comb begin
        state_nxt  = state;
        cnt_rd_nxt = cnt_rd;
        addr_in    = '0;
        dram_en_rd = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                addr_in    = OFMAP_BASE + ADDR_WIDTH'(cnt_rd);
                dram_en_rd = 1'b1;
                if (cnt_rd == LAST_IDX) begin
                    cnt_rd_nxt = '0;
                    state_nxt  = DRAIN;
                end else begin
                    cnt_rd_nxt = cnt_rd + 1'b1;
                end
            end
            DRAIN: begin
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Index 0 always loads so an all-negative map still reports a real
    // score; strict greater-than keeps the lowest index on ties.
    always_comb begin
        take    = rd_vld && ((rd_idx == '0) ||
                  ($signed(data_in) > $signed(run_max)));
        max_nxt = take ? data_in : run_max;
        idx_nxt = take ? rd_idx  : run_idx;
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state     <= IDLE;
            cnt_rd    <= '0;
            rd_vld    <= 1'b0;
            rd_idx    <= '0;
            run_max   <= '0;
            run_idx   <= '0;
            class_idx <= '0;
            max_val   <= '0;
            done      <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt_rd  <= cnt_rd_nxt;
            rd_vld  <= dram_en_rd;
            rd_idx  <= cnt_rd;
            run_max <= max_nxt;
            run_idx <= idx_nxt;
            done    <= (state == DRAIN);
            // The last word arrives during DRAIN, so results are taken
            // from the combined next-max rather than the stored one.
            if (state == DRAIN) begin
                class_idx <= idx_nxt;
                max_val   <= max_nxt;
            end
        end
    end

endmodule

// File: tb/tb_argmax_reader.sv
// tb_argmax_reader: directed self-checking bench for argmax_reader
// with a one-cycle-latency DRAM model.
module tb_argmax_reader;

    localparam int BASE = 131072;

    logic        clk;
    logic        srstn;
    logic        enable;
    logic [31:0] data_in;
    logic [17:0] addr_in;
    logic        dram_en_rd;
    logic [3:0]  class_idx;
    logic [31:0] max_val;
    logic        done;

    int          ntests;
    int          nfail;
    int          sc [10];
    logic [31:0] mem [10];

    logic        r_addr_ok;
    int          r_done_cyc;
    int          r_done_cnt;
    logic [3:0]  r_idx;
    logic [31:0] r_max;

    argmax_reader dut (
        .clk        (clk),
        .srstn      (srstn),
        .enable     (enable),
        .data_in    (data_in),
        .addr_in    (addr_in),
        .dram_en_rd (dram_en_rd),
        .class_idx  (class_idx),
        .max_val    (max_val),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dram_en_rd && addr_in >= 18'(BASE) && addr_in < 18'(BASE + 10))
            data_in <= mem[addr_in - 18'(BASE)];
        else
            data_in <= 32'hDEADBEEF;
    end

    task automatic load_mem();
        for (int i = 0; i < 10; i++) mem[i] = 32'(sc[i] * 65536);
    endtask

    // Starts one run from a negedge and observes cycles E+1..E+20.
    task automatic do_run();
        r_addr_ok  = 1'b1;
        r_done_cyc = -1;
        r_done_cnt = 0;
        r_idx      = 'x;
        r_max      = 'x;
        enable = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) enable = 1'b0;
            if (c <= 10) begin
                if (dram_en_rd !== 1'b1 || addr_in !== 18'(BASE + c - 1))
                    r_addr_ok = 1'b0;
            end else if (dram_en_rd !== 1'b0) begin
                r_addr_ok = 1'b0;
            end
            if (done === 1'b1) begin
                r_done_cnt++;
                if (r_done_cyc < 0) begin
                    r_done_cyc = c;
                    r_idx      = class_idx;
                    r_max      = max_val;
                end
            end
        end
    endtask

    task automatic test_reset();
        srstn  = 1'b0;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        ntests++;
        if (addr_in !== 18'd0) begin
            nfail++; $display("FAIL reset_addr: got %0d want 0", addr_in);
        end
        ntests++;
        if (dram_en_rd !== 1'b0) begin
            nfail++; $display("FAIL reset_en: got %b want 0", dram_en_rd);
        end
        ntests++;
        if (class_idx !== 4'd0) begin
            nfail++; $display("FAIL reset_idx: got %0d want 0", class_idx);
        end
        ntests++;
        if (max_val !== 32'd0) begin
            nfail++; $display("FAIL reset_max: got %h want 0", max_val);
        end
        ntests++;
        if (done !== 1'b0) begin
            nfail++; $display("FAIL reset_done: got %b want 0", done);
        end
        srstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_distinct();
        sc = '{3, 7, 1, 9, 2, 0, 5, 8, 4, 6};
        load_mem();
        do_run();
        ntests++;
        if (r_addr_ok !== 1'b1) begin
            nfail++; $display("FAIL distinct_addr: got bad sequence want base+0..9");
        end
        ntests++;
        if (r_done_cyc != 12 || r_done_cnt != 1) begin
            nfail++;
            $display("FAIL distinct_done: got cyc %0d cnt %0d want 12 1",
                     r_done_cyc, r_done_cnt);
        end
        ntests++;
        if (r_idx !== 4'd3) begin
            nfail++; $display("FAIL distinct_idx: got %0d want 3", r_idx);
        end
        ntests++;
        if (r_max !== 32'h0009_0000) begin
            nfail++; $display("FAIL distinct_max: got %h want 00090000", r_max);
        end
    endtask

    task automatic test_tie();
        sc = '{1, 2, 5, 3, 0, 4, -2, 5, 1, 2};
        load_mem();
        do_run();
        ntests++;
        if (r_idx !== 4'd2) begin
            nfail++; $display("FAIL tie_idx: got %0d want 2", r_idx);
        end
        ntests++;
        if (r_max !== 32'h0005_0000) begin
            nfail++; $display("FAIL tie_max: got %h want 00050000", r_max);
        end
    endtask

    task automatic test_all_negative();
        sc = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10};
        load_mem();
        do_run();
        ntests++;
        if (r_idx !== 4'd0) begin
            nfail++; $display("FAIL neg_idx: got %0d want 0", r_idx);
        end
        ntests++;
        if (r_max !== 32'hFFFF_0000) begin
            nfail++; $display("FAIL neg_max: got %h want ffff0000", r_max);
        end
    endtask

    task automatic test_last_index();
        sc = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 10};
        load_mem();
        do_run();
        ntests++;
        if (r_idx !== 4'd9) begin
            nfail++; $display("FAIL last_idx: got %0d want 9", r_idx);
        end
        ntests++;
        if (r_max !== 32'h000A_0000) begin
            nfail++; $display("FAIL last_max: got %h want 000a0000", r_max);
        end
    endtask

    // Previous run left idx 9 / 10.0; results must hold until next done.
    task automatic test_hold();
        logic held;
        int   dcyc;
        logic [3:0] didx;
        held = 1'b1;
        dcyc = -1;
        didx = 'x;
        sc = '{3, 7, 1, 9, 2, 0, 5, 8, 4, 6};
        load_mem();
        repeat (3) begin
            @(negedge clk);
            if (class_idx !== 4'd9 || max_val !== 32'h000A_0000) held = 1'b0;
        end
        enable = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) enable = 1'b0;
            if (c < 12 && (class_idx !== 4'd9 || max_val !== 32'h000A_0000))
                held = 1'b0;
            if (done === 1'b1 && dcyc < 0) begin
                dcyc = c;
                didx = class_idx;
            end
        end
        ntests++;
        if (held !== 1'b1) begin
            nfail++; $display("FAIL hold_values: got changed want idx 9 max 000a0000");
        end
        ntests++;
        if (dcyc != 12 || didx !== 4'd3) begin
            nfail++;
            $display("FAIL hold_next: got cyc %0d idx %0d want 12 3", dcyc, didx);
        end
    endtask

    task automatic test_back_to_back();
        int d [3];
        int n;
        logic idx_ok;
        n = 0;
        idx_ok = 1'b1;
        d = '{-1, -1, -1};
        sc = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 10};
        load_mem();
        enable = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (n < 3) d[n] = c;
                n++;
                if (class_idx !== 4'd9) idx_ok = 1'b0;
            end
        end
        enable = 1'b0;
        repeat (20) @(negedge clk);
        ntests++;
        if (n != 3 || d[0] != 12 || d[1] != 25 || d[2] != 38) begin
            nfail++;
            $display("FAIL b2b_done: got n %0d at %0d %0d %0d want 3 at 12 25 38",
                     n, d[0], d[1], d[2]);
        end
        ntests++;
        if (idx_ok !== 1'b1) begin
            nfail++; $display("FAIL b2b_idx: got wrong idx want 9");
        end
    endtask

    task automatic test_enable_in_read();
        int n;
        int first;
        n = 0;
        first = -1;
        enable = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) enable = 1'b0;
            if (c == 4) enable = 1'b1;
            if (c == 5) enable = 1'b0;
            if (done === 1'b1) begin
                n++;
                if (first < 0) first = c;
            end
        end
        ntests++;
        if (n != 1 || first != 12) begin
            nfail++;
            $display("FAIL read_pulse: got %0d dones first %0d want 1 at 12",
                     n, first);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        sc = '{1, 100, 2, 3, 4, 5, 6, 7, 8, 9};
        load_mem();
        enable = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) enable = 1'b0;
        end
        srstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ntests++;
        if (dram_en_rd !== 1'b0 || addr_in !== 18'd0) begin
            nfail++;
            $display("FAIL midrst_rd: got en %b addr %0d want 0 0",
                     dram_en_rd, addr_in);
        end
        ntests++;
        if (class_idx !== 4'd0 || max_val !== 32'd0 || done !== 1'b0) begin
            nfail++;
            $display("FAIL midrst_out: got idx %0d max %h done %b want 0 0 0",
                     class_idx, max_val, done);
        end
        srstn = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        ntests++;
        if (n != 0) begin
            nfail++; $display("FAIL midrst_nodone: got %0d dones want 0", n);
        end
        sc = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10};
        load_mem();
        do_run();
        ntests++;
        if (r_done_cyc != 12 || r_idx !== 4'd0 || r_max !== 32'hFFFF_0000) begin
            nfail++;
            $display("FAIL midrst_fresh: got cyc %0d idx %0d max %h want 12 0 ffff0000",
                     r_done_cyc, r_idx, r_max);
        end
    endtask

    initial begin
        ntests  = 0;
        nfail   = 0;
        srstn   = 1'b0;
        enable  = 1'b0;
        for (int i = 0; i < 10; i++) mem[i] = '0;
        test_reset();
        test_distinct();
        test_tie();
        test_all_negative();
        test_last_index();
        test_hold();
        test_back_to_back();
        test_enable_in_read();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
